// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - two-player button debounce, LFSR dice and roll/lock FSMs
// Each die rolls while its debounced button is held and stays frozen until the scorer ends the round.
module dice_roller #(
   parameter int         DEBOUNCE_CYC = 20000,
   parameter int         ROLL_DIV     = 50000,
   parameter logic [7:0] SEED1        = 8'h5A,
   parameter logic [7:0] SEED2        = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn1,
   input  logic       i_btn2,
   input  logic       i_times,
   output logic       o_start1,
   output logic       o_start2,
   output logic [3:0] o_dice1,
   output logic [3:0] o_dice2,
   output logic       o_locked1,
   output logic       o_locked2,
   output logic       o_both_locked
);

   localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int RW = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [RW-1:0] ROLL_MAX = RW'(ROLL_DIV - 1);

   typedef enum logic [1:0] {IDLE, ROLL, LOCK} state_t;

   logic [1:0]    r_btn_meta, r_btn_sync, r_stable, r_stable_d;
   logic          r_times_meta, r_times_sync, r_times_d;
   logic [DW-1:0] r_deb [2];
   logic [7:0]    r_lfsr [2];
   logic [RW-1:0] r_div [2], w_div_nxt [2];
   logic [3:0]    r_dice [2], w_dice_nxt [2], w_sum [2];
   state_t        r_state [2], w_state_nxt [2];
   logic [1:0]    r_start, w_start_nxt, r_locked, w_locked_nxt;
   logic          r_both;
   logic [1:0]    w_rise, w_fall;
   logic          w_times_fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btn_meta   <= '0;
         r_btn_sync   <= '0;
         r_stable_d   <= '0;
         r_times_meta <= 1'b0;
         r_times_sync <= 1'b0;
         r_times_d    <= 1'b0;
      end else begin
         r_btn_meta   <= {i_btn2, i_btn1};
         r_btn_sync   <= r_btn_meta;
         r_stable_d   <= r_stable;
         r_times_meta <= i_times;
         r_times_sync <= r_times_meta;
         r_times_d    <= r_times_sync;
      end
   end

   // Debounce accepts a level only after DEBOUNCE_CYC consecutive differing samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            r_deb[i] <= '0;
         end
         r_stable  <= '0;
         r_lfsr[0] <= SEED1;
         r_lfsr[1] <= SEED2;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_btn_sync[i] != r_stable[i]) begin
               if (r_deb[i] == DEB_MAX) begin
                  r_stable[i] <= r_btn_sync[i];
                  r_deb[i]    <= '0;
               end else begin
                  r_deb[i] <= r_deb[i] + 1'b1;
               end
            end else begin
               r_deb[i] <= '0;
            end
            r_lfsr[i] <= {r_lfsr[i][6:0], ^(r_lfsr[i] & 8'hB8)};
         end
      end
   end

   assign w_rise       = r_stable & ~r_stable_d;
   assign w_fall       = ~r_stable & r_stable_d;
   assign w_times_fall = ~r_times_sync & r_times_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            r_state[i] <= IDLE;
            r_div[i]   <= '0;
            r_dice[i]  <= '0;
         end
         r_start  <= '0;
         r_locked <= '0;
         r_both   <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_div[i]   <= w_div_nxt[i];
            r_dice[i]  <= w_dice_nxt[i];
         end
         r_start  <= w_start_nxt;
         r_locked <= w_locked_nxt;
         r_both   <= r_locked[0] & r_locked[1];
      end
   end

   always_comb begin
      w_start_nxt  = r_start;
      w_locked_nxt = r_locked;
      for (int i = 0; i < 2; i++) begin
         w_state_nxt[i] = r_state[i];
         w_div_nxt[i]   = r_div[i];
         w_dice_nxt[i]  = r_dice[i];
         w_sum[i]       = r_dice[i] + 4'd1 + {2'b00, r_lfsr[i][1:0]};
         if (w_sum[i] > 4'd6) begin
            w_sum[i] = w_sum[i] - 4'd6;
         end
         case (r_state[i])
            IDLE: begin
               if (w_rise[i] && !r_times_sync) begin
                  w_state_nxt[i] = ROLL;
                  w_div_nxt[i]   = '0;
                  w_start_nxt[i] = 1'b1;
               end
            end
            ROLL: begin
               // Release wins over a terminal count so the value seen at start's fall is final.
               if (w_fall[i]) begin
                  w_state_nxt[i]  = LOCK;
                  w_start_nxt[i]  = 1'b0;
                  w_locked_nxt[i] = 1'b1;
               end else if (r_div[i] == ROLL_MAX) begin
                  w_div_nxt[i]  = '0;
                  w_dice_nxt[i] = w_sum[i];
               end else begin
                  w_div_nxt[i] = r_div[i] + 1'b1;
               end
            end
            LOCK: begin
               if (w_times_fall) begin
                  w_state_nxt[i]  = IDLE;
                  w_locked_nxt[i] = 1'b0;
               end
            end
            default: begin
               w_state_nxt[i] = IDLE;
            end
         endcase
      end
   end

   assign o_start1      = r_start[0];
   assign o_start2      = r_start[1];
   assign o_dice1       = r_dice[0];
   assign o_dice2       = r_dice[1];
   assign o_locked1     = r_locked[0];
   assign o_locked2     = r_locked[1];
   assign o_both_locked = r_both;

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - scoreboard bench for dice_roller
// Expected output events are queued when stimulus is issued and popped by an output-change monitor.
module tb_dice_roller;

   localparam logic [7:0] S1 = 8'h5A;
   localparam logic [7:0] S2 = 8'hA5;
   localparam int K_SU = 0, K_SD = 1, K_LU = 2, K_LD = 3, K_DICE = 4, K_BU = 5, K_BD = 6;
   localparam int M_IDLE = 0, M_LOCK = 2;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn1 = 1'b0, btn2 = 1'b0, times = 1'b0;
   logic       start1, start2, locked1, locked2, both_locked;
   logic [3:0] dice1, dice2;

   int  cyc;
   int  checks = 0;
   int  errors = 0;
   ev_t q[3][$];
   int  mdice[3], mst[3], mlock[3];
   logic       pst[3], plk[3];
   logic [3:0] pdc[3];
   logic       pboth;

   dice_roller #(
      .DEBOUNCE_CYC(4),
      .ROLL_DIV    (3),
      .SEED1       (S1),
      .SEED2       (S2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_btn1       (btn1),
      .i_btn2       (btn2),
      .i_times      (times),
      .o_start1     (start1),
      .o_start2     (start2),
      .o_dice1      (dice1),
      .o_dice2      (dice2),
      .o_locked1    (locked1),
      .o_locked2    (locked2),
      .o_both_locked(both_locked)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   function automatic logic [7:0] lfsr_at(input logic [7:0] seed, input int k);
      logic [7:0] r;
      r = seed;
      for (int j = 0; j < k; j++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
      return r;
   endfunction

   task automatic push(input int p, input int kind, input int val, input int c);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = c;
      q[p].push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic got(input int p, input int kind, input int val);
      ev_t e;
      checks++;
      if (q[p].size() == 0) begin
         errors++;
         $display("FAIL event_q%0d: got kind %0d val %0d at cyc %0d, required no event", p, kind, val, cyc);
      end else begin
         e = q[p].pop_front();
         if (e.kind != kind || e.val != val || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_q%0d: got kind %0d val %0d cyc %0d, required kind %0d val %0d cyc %0d",
                     p, kind, val, cyc, e.kind, e.val, e.cyc);
         end
      end
   endtask

   task automatic mon_p(input int p, input logic st, input logic lk, input logic [3:0] dc);
      if (st !== pst[p]) got(p, st ? K_SU : K_SD, 0);
      if (lk !== plk[p]) got(p, lk ? K_LU : K_LD, 0);
      if (dc !== pdc[p]) got(p, K_DICE, int'(dc));
      pst[p] = st;
      plk[p] = lk;
      pdc[p] = dc;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            pst[i] = 1'b0;
            plk[i] = 1'b0;
            pdc[i] = 4'd0;
         end
         pboth = 1'b0;
      end else begin
         mon_p(1, start1, locked1, dice1);
         mon_p(2, start2, locked2, dice2);
         if (both_locked !== pboth) got(0, both_locked ? K_BU : K_BD, 0);
         pboth = both_locked;
      end
   end

   // Press at cycle n, planned release at cycle m, tv = raw times level around the press.
   task automatic plan(input int p, input int n, input int m, input logic tv);
      int t, d, o;
      logic [7:0] seed;
      t = n + 7;
      if (mst[p] != M_IDLE || tv) return;
      seed = (p == 1) ? S1 : S2;
      push(p, K_SU, 0, t);
      d = mdice[p];
      for (int e = t + 3; e < m + 7; e += 3) begin
         d = d + 1 + int'(lfsr_at(seed, e - 1) & 8'h03);
         if (d > 6) d = d - 6;
         push(p, K_DICE, d, e);
      end
      push(p, K_SD, 0, m + 7);
      push(p, K_LU, 0, m + 7);
      mdice[p] = d;
      mst[p]   = M_LOCK;
      mlock[p] = m + 7;
      o = 3 - p;
      if (mst[o] == M_LOCK) push(0, K_BU, 0, ((mlock[o] > mlock[p]) ? mlock[o] : mlock[p]) + 1);
   endtask

   task automatic set_btn(input int p, input logic v);
      if (p == 1) btn1 = v;
      else        btn2 = v;
   endtask

   task automatic do_press(input int p, input int hold);
      int n;
      n = cyc;
      set_btn(p, 1'b1);
      plan(p, n, n + hold, times);
      repeat (hold) @(negedge clk);
      set_btn(p, 1'b0);
      repeat (9) @(negedge clk);
   endtask

   task automatic end_round();
      int b;
      b = cyc;
      times = 1'b0;
      if (mst[1] == M_LOCK && mst[2] == M_LOCK) push(0, K_BD, 0, b + 4);
      for (int p = 1; p <= 2; p++) begin
         if (mst[p] == M_LOCK) begin
            push(p, K_LD, 0, b + 3);
            mst[p] = M_IDLE;
         end
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic round_trip(input int len);
      times = 1'b1;
      repeat (len) @(negedge clk);
      end_round();
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         q[i].delete();
         mdice[i] = 0;
         mst[i]   = M_IDLE;
         mlock[i] = 0;
      end
   endtask

   initial begin
      int n;
      model_reset();
      repeat (5) @(negedge clk);
      chk("reset_outputs_first", {start1, start2, locked1, locked2, both_locked, dice1, dice2}, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         btn1 = (i % 2 == 0);
         repeat (2) @(negedge clk);
      end
      btn1 = 1'b0;
      repeat (12) @(negedge clk);
      chk("bounce_start1", start1, 0);
      chk("bounce_dice1", dice1, 0);

      n = cyc;
      btn1 = 1'b1;
      plan(1, n, n + 1000, times);
      repeat (12) @(negedge clk);
      chk("midroll_start1_before", start1, 1);
      rst = 1'b0;
      #1;
      chk("midroll_reset_start1", start1, 0);
      chk("midroll_reset_dice1", dice1, 0);
      model_reset();
      btn2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset_outputs", {start1, start2, locked1, locked2, both_locked, dice1, dice2}, 0);
      end
      rst = 1'b1;
      plan(1, 0, 30, 1'b0);
      plan(2, 0, 20, 1'b0);
      wait_to(20);
      btn2 = 1'b0;
      wait_to(30);
      btn1 = 1'b0;
      wait_to(40);

      repeat (100) @(negedge clk);
      chk("lock_dice1_held", dice1, mdice[1]);
      chk("lock_locked1", locked1, 1);
      chk("lock_both", both_locked, 1);
      do_press(1, 12);
      chk("lock_press_start1", start1, 0);

      round_trip(10);
      chk("round_dice1_kept", dice1, mdice[1]);
      chk("round_dice2_kept", dice2, mdice[2]);
      chk("round_unlocked", {locked1, locked2, both_locked}, 0);

      times = 1'b1;
      repeat (3) @(negedge clk);
      n = cyc;
      btn2 = 1'b1;
      plan(2, n, n + 30, times);
      repeat (8) @(negedge clk);
      chk("inround_start2", start2, 0);
      chk("inround_dice2", dice2, mdice[2]);
      end_round();
      repeat (10) @(negedge clk);
      btn2 = 1'b0;
      repeat (10) @(negedge clk);
      chk("after_round_start2", start2, 0);
      do_press(2, 15);

      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(1, 0) == 1) begin
            do_press(1, $urandom_range(40, 8));
            do_press(2, $urandom_range(40, 8));
         end else begin
            do_press(2, $urandom_range(40, 8));
            do_press(1, $urandom_range(40, 8));
         end
         if ($urandom_range(1, 0) == 1) do_press($urandom_range(2, 1), $urandom_range(20, 8));
         chk("rand_dice1", dice1, mdice[1]);
         chk("rand_dice2", dice2, mdice[2]);
         round_trip($urandom_range(15, 3));
      end

      repeat (20) @(negedge clk);
      for (int i = 0; i < 3; i++) chk("pending_events", q[i].size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at cyc %0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
